paddle2quad: RTL

//   Converts an absolute 8-bit paddle/analog-stick position into quadrature pulses
//   {A,B} for the game core's Enc_A/Enc_B inputs. Lets analog controls drive the

---
 rtl/paddle2quad_pkg.sv | 23 ++
 rtl/paddle2quad_if.sv | 20 ++
 rtl/quad_phase_gen.sv | 38 +++
 rtl/paddle2quad.sv | 117 +++++++++++
 4 files changed

// File: rtl/paddle2quad_pkg.sv
// Shared types and helpers for the paddle-to-quadrature converter.
//   p2q_state_e : tracking FSM states
//   QUAD_SEQ    : quadrature {A,B} pattern, indexed by 2-bit phase
//   map_sample  : maps a raw sample to the unsigned 0..255 position domain
package paddle2quad_pkg;

  typedef enum logic [1:0] {
    SYNC    = 2'd0,
    IDLE    = 2'd1,
    STEP_UP = 2'd2,
    STEP_DN = 2'd3
  } p2q_state_e;

  localparam logic [1:0] QUAD_SEQ [0:3] = '{2'b00, 2'b01, 2'b11, 2'b10};

  // Two's complement sticks are re-centred by flipping the sign bit, so that
  // -128..127 becomes 0..255 with 0 landing at mid-travel.
  function automatic logic [7:0] map_sample(input logic [7:0] pos,
                                            input logic       signed_in);
    return signed_in ? (pos ^ 8'h80) : pos;
  endfunction

endpackage

// File: rtl/paddle2quad_if.sv
// Sample/quadrature bundle between the input controller and paddle2quad.
//   enable    : 1 = track, 0 = freeze output and force resync
//   pos_valid : one-cycle strobe, pos holds a new sample
//   pos       : 8-bit position sample
//   signed_in : pos is two's complement
//   steer     : quadrature {A,B}
//   busy      : steps toward the target are pending
interface paddle2quad_if;
  logic       enable;
  logic       pos_valid;
  logic [7:0] pos;
  logic       signed_in;
  logic [1:0] steer;
  logic       busy;

  modport master (output enable, pos_valid, pos, signed_in,
                  input  steer, busy);
  modport slave  (input  enable, pos_valid, pos, signed_in,
                  output steer, busy);
endinterface

// File: rtl/quad_phase_gen.sv
// Quadrature phase generator: a 2-bit phase index moved by single-cycle
// up/down strobes, with {A,B} registered straight from the next phase so the
// output changes exactly one bit per step and never glitches.
//   clk_sys : system clock
//   reset_n : async active-low reset (phase 0, steer 00)
//   step_up : advance one phase
//   step_dn : retreat one phase (ignored if step_up is also set)
//   steer   : quadrature {A,B}
module quad_phase_gen
  import paddle2quad_pkg::*;
(
  input  logic       clk_sys,
  input  logic       reset_n,
  input  logic       step_up,
  input  logic       step_dn,
  output logic [1:0] steer
);

  logic [1:0] idx;
  logic [1:0] idx_nxt;

  always_comb begin
    idx_nxt = idx;
    if (step_up)      idx_nxt = idx + 2'd1;
    else if (step_dn) idx_nxt = idx - 2'd1;
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      idx   <= 2'd0;
      steer <= 2'b00;
    end else begin
      idx   <= idx_nxt;
      steer <= QUAD_SEQ[idx_nxt];
    end
  end

endmodule

// File: rtl/paddle2quad.sv
// Absolute 8-bit paddle position to quadrature converter. Tracks the last
// emitted position (current) and walks it toward the latest sample (target)
// one quadrature step every CLKDIV clocks. DEADBAND filters jitter at rest
// only; once moving the walk always finishes on the target.
//   clk_sys : system clock
//   reset_n : async active-low reset
//   bus     : slave side of paddle2quad_if (samples in, steer/busy out)
module paddle2quad
  import paddle2quad_pkg::*;
#(
  parameter int CLKDIV   = 5500,
  parameter int DEADBAND = 1
) (
  input  logic          clk_sys,
  input  logic          reset_n,
  paddle2quad_if.slave  bus
);

  localparam int                DIV_W = (CLKDIV > 2) ? $clog2(CLKDIV) : 1;
  localparam logic [DIV_W-1:0]  DIV_MAX = DIV_W'(CLKDIV - 1);
  localparam logic signed [8:0] DB_S    = 9'(DEADBAND);

  p2q_state_e        state;
  logic [7:0]        target;
  logic [7:0]        current;
  logic [DIV_W-1:0]  div;
  logic              busy_q;

  logic [7:0]        pos_u;
  logic signed [8:0] diff;
  logic              moving;
  logic              tick;
  logic              step_up;
  logic              step_dn;

  assign pos_u  = map_sample(bus.pos, bus.signed_in);
  // Both operands are 0..255, so 9 bits hold the difference without overflow.
  assign diff   = $signed({1'b0, target}) - $signed({1'b0, current});
  assign moving = (state == STEP_UP) || (state == STEP_DN);
  assign tick   = moving && (div == DIV_MAX);

  // Step decisions use the registered (old) target; a sample arriving on the
  // tick edge only takes effect from the next decision onward.
  assign step_up = bus.enable && tick && (diff > 9'sd0);
  assign step_dn = bus.enable && tick && (diff < 9'sd0);

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state   <= SYNC;
      target  <= 8'd0;
      current <= 8'd0;
      div     <= '0;
      busy_q  <= 1'b0;
    end else if (!bus.enable) begin
      // Freeze: steer keeps its last level, next sample resyncs silently.
      state  <= SYNC;
      div    <= '0;
      busy_q <= 1'b0;
    end else begin
      case (state)
        SYNC: begin
          div <= '0;
          if (bus.pos_valid) begin
            target  <= pos_u;
            current <= pos_u;
            state   <= IDLE;
          end
        end
        IDLE: begin
          div <= '0;
          if (diff > DB_S) begin
            state  <= STEP_UP;
            busy_q <= 1'b1;
          end else if (diff < -DB_S) begin
            state  <= STEP_DN;
            busy_q <= 1'b1;
          end
          if (bus.pos_valid) target <= pos_u;
        end
        STEP_UP, STEP_DN: begin
          if (tick) begin
            div <= '0;
            if (step_up) begin
              current <= current + 8'd1;
              state   <= STEP_UP;
            end else if (step_dn) begin
              current <= current - 8'd1;
              state   <= STEP_DN;
            end else begin
              state  <= IDLE;
              busy_q <= 1'b0;
            end
          end else begin
            div <= div + 1'b1;
          end
          if (bus.pos_valid) target <= pos_u;
        end
        default: begin
          state  <= SYNC;
          div    <= '0;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy = busy_q;

  quad_phase_gen u_phase (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .step_up (step_up),
    .step_dn (step_dn),
    .steer   (bus.steer)
  );

endmodule
